timer_lease_arbiter: RTL
========================

TIMER_LEASE_ARBITER -- requirements
Module: timer_lease_arbiter

Interface
REQ-001 Parameter: LEASE_CYCLES, 0, maximum RUN cycles of a PWM lease; 0 disables the timeout.
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 req  in  4  per-requester lease request, level; bit i = requester i.
REQ-005 req_mode  in  8  requester i mode in [2i+1:2i]; 01=INT, 10=PWM, 00/11 invalid.
REQ-006 req_prescalor  in  128  requester i prescaler value in [32i+31:32i].
REQ-007 req_max_count  in  128  requester i period value in [32i+31:32i].
REQ-008 req_compare  in  128  requester i duty compare in [32i+31:32i].
REQ-009 release  in  4  per-requester voluntary lease release, level.
REQ-010 timer_int  in  1  interrupt output of the shared timer/counter.
REQ-011 gnt  out  4  one-hot lease grant, registered.
REQ-012 control  out  2  mode driven to the timer (00 off, 01 INT, 10 PWM).
REQ-013 prescalor, max_count, compare  out  32 each  configuration driven to the timer.
REQ-014 done  out  4  one-cycle pulse to the owner on INT-mode expiry.
REQ-015 busy  out  1  high whenever a lease is held (state != IDLE).

Function
REQ-016 FSM states: IDLE, SETUP, RUN; all outputs registered.
REQ-017 A requester is eligible when req[i]=1 and req_mode[i] is 01 or 10; invalid modes are masked and never granted.
REQ-018 IDLE: control=00, config outputs=0, gnt=0; when any requester is eligible, select the owner round-robin starting at last_owner+1 mod 4, capture its mode/prescalor/max_count/compare, set gnt[owner], and go to SETUP.
REQ-019 Config outputs take the captured values on entry to SETUP and hold them, unchanged, until return to IDLE; later changes on req_* inputs are ignored.
REQ-020 SETUP lasts exactly one cycle with control=00, which forces the timer's mode-change reset; the FSM then goes to RUN with control=captured mode.
REQ-021 Latency: req sampled at edge t gives gnt=1 after edge t+1 and control=mode after edge t+2.
REQ-022 Rising-edge detection of timer_int uses a registered copy; the copy is cleared in IDLE and SETUP.
REQ-023 RUN, INT mode: on a timer_int rising edge, pulse done[owner] for one cycle, drop gnt, update last_owner, and go to IDLE.
REQ-024 RUN, either mode: release[owner]=1 or req[owner]=0 ends the lease (IDLE next) without a done pulse.
REQ-025 RUN, PWM mode with LEASE_CYCLES>0: the lease ends after LEASE_CYCLES RUN cycles; the 32-bit run counter is cleared on SETUP entry.
REQ-026 Simultaneous timer_int edge and release in INT mode: done is pulsed and the lease ends.
REQ-027 release or req changes of non-owners have no effect during a lease.
REQ-028 Minimum gap between leases is two cycles with control=00 (IDLE + SETUP).
REQ-029 last_owner is updated on every lease end, aborted or completed.

Reset
REQ-030 Reset is synchronous: the state goes to IDLE and gnt, done, busy, control, prescalor, max_count, compare and the run counter all go to 0.
REQ-031 Reset sets last_owner=3, so requester 0 has first priority; reset mid-lease abandons the lease and produces no done pulse.

Structure
REQ-032 Shared package timer_pkg holds the mode constants (MODE_OFF, MODE_INT, MODE_PWM) and the FSM state encoding.
REQ-033 The round-robin selection is a combinational sub-module, rr_arbiter4 (eligible[3:0] and last_owner in, one-hot grant out).

Verification
REQ-034 req=0001, mode0=01, prescalor0=0, max_count0=3: gnt=0001 next cycle, one SETUP cycle with control=00, then control=01; done[0] pulses once at the first timer_int edge, then IDLE.
REQ-035 req=1111 held, all in INT mode: grants go in the order 0,1,2,3,0, and each pair of leases is separated by at least 2 cycles with control=00.
REQ-036 req=0010, mode1=10, compare1=2, max_count1=4, release[1] asserted after 20 RUN cycles: no done pulse, gnt=0 next cycle, control=00.
REQ-037 LEASE_CYCLES=8, PWM lease on requester 2: after exactly 8 RUN cycles the FSM returns to IDLE and requester 3 is granted next if eligible.
REQ-038 Requester 0 with mode 11 and requester 1 with mode 01: only requester 1 is granted; reset asserted during RUN gives all outputs 0 next cycle and no done.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared constants for the timer lease arbiter: timer modes, FSM states,
// and small decode helpers.
package timer_pkg;

  localparam logic [1:0] MODE_OFF = 2'b00;
  localparam logic [1:0] MODE_INT = 2'b01;
  localparam logic [1:0] MODE_PWM = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_RUN
  } state_t;

  function automatic logic mode_valid(input logic [1:0] mode);
    return (mode == MODE_INT) || (mode == MODE_PWM);
  endfunction

  function automatic logic [1:0] onehot_to_idx(input logic [3:0] oh);
    logic [1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (oh[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_arbiter4.sv
// Combinational 4-way round-robin pick: search starts at last_owner+1.
module rr_arbiter4
  import timer_pkg::*;
(
  input  logic [3:0] eligible,
  input  logic [1:0] last_owner,
  output logic [3:0] grant
);

  logic       found;
  logic [1:0] idx;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 1; k <= 4; k++) begin
      idx = 2'(32'(last_owner) + k);
      if (!found && eligible[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/timer_lease_arbiter.sv
// Leases one shared timer/counter to one of four requesters at a time,
// driving its mode and configuration for the duration of the lease.
module timer_lease_arbiter
  import timer_pkg::*;
#(
  parameter int unsigned LEASE_CYCLES = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [3:0]   req,
  input  logic [7:0]   req_mode,
  input  logic [127:0] req_prescalor,
  input  logic [127:0] req_max_count,
  input  logic [127:0] req_compare,
  // "release" is a reserved word, hence the short name
  input  logic [3:0]   rel,
  input  logic         timer_int,
  output logic [3:0]   gnt,
  output logic [1:0]   control,
  output logic [31:0]  prescalor,
  output logic [31:0]  max_count,
  output logic [31:0]  compare,
  output logic [3:0]   done,
  output logic         busy
);

  state_t      state;
  logic [1:0]  last_owner;
  logic [1:0]  owner;
  logic [1:0]  mode_q;
  logic [31:0] run_cnt;
  logic        tint_q;
  logic [3:0]  eligible;
  logic [3:0]  pick;
  logic [1:0]  sel;
  logic        int_done;
  logic        abort;
  logic        timeout;

  always_comb begin
    eligible = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      eligible[i] = req[i] & mode_valid(req_mode[2*i +: 2]);
    end
  end

  rr_arbiter4 u_rr (
    .eligible   (eligible),
    .last_owner (last_owner),
    .grant      (pick)
  );

  always_comb begin
    sel      = onehot_to_idx(pick);
    int_done = (mode_q == MODE_INT) && timer_int && !tint_q;
    abort    = rel[owner] || !req[owner];
    timeout  = (mode_q == MODE_PWM) && (LEASE_CYCLES != 0) &&
               (run_cnt == 32'(LEASE_CYCLES - 1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      gnt        <= '0;
      done       <= '0;
      busy       <= 1'b0;
      control    <= MODE_OFF;
      prescalor  <= '0;
      max_count  <= '0;
      compare    <= '0;
      run_cnt    <= '0;
      tint_q     <= 1'b0;
      last_owner <= 2'd3;
      owner      <= '0;
      mode_q     <= MODE_OFF;
    end else begin
      done <= '0;
      case (state)
        ST_IDLE: begin
          tint_q <= 1'b0;
          if (|eligible) begin
            owner     <= sel;
            gnt       <= pick;
            mode_q    <= req_mode[2*sel +: 2];
            prescalor <= req_prescalor[32*sel +: 32];
            max_count <= req_max_count[32*sel +: 32];
            compare   <= req_compare[32*sel +: 32];
            run_cnt   <= '0;
            busy      <= 1'b1;
            state     <= ST_SETUP;
          end
        end
        // control stays off for this cycle so the timer sees a mode change
        ST_SETUP: begin
          tint_q  <= 1'b0;
          control <= mode_q;
          state   <= ST_RUN;
        end
        ST_RUN: begin
          tint_q <= timer_int;
          if (int_done || abort || timeout) begin
            if (int_done) done[owner] <= 1'b1;
            gnt        <= '0;
            control    <= MODE_OFF;
            prescalor  <= '0;
            max_count  <= '0;
            compare    <= '0;
            busy       <= 1'b0;
            last_owner <= owner;
            state      <= ST_IDLE;
          end else begin
            run_cnt <= run_cnt + 32'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
